// File: rtl/scan_display_ctrl_if.sv
// Host-side controls and board-pin outputs of the multiplexed seven-segment controller.
interface scan_display_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    lz_suppress;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_done;
    logic                    load_ack;

    modport master (
        output en, load, value, lz_suppress,
        input  seg, dig_en, frame_done, load_ack
    );
    modport slave (
        input  en, load, value, lz_suppress,
        output seg, dig_en, frame_done, load_ack
    );
endinterface

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-boundary commit of new display words.
// State | meaning:  SHOW | digit idx lit for REFRESH_DIV cycles;  GAP | all digits blank between digits
module scan_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 8
) (
    input  logic               clk,
    input  logic               rst,
    scan_display_ctrl_if.slave bus
);
    localparam int W    = 4 * NUM_DIGITS;
    localparam int MAXC = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              parked_q, parked_d;
    logic [W-1:0]      disp_q, disp_d;
    logic [W-1:0]      pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [6:0]        seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic              fd_q, fd_d;
    logic              ack_q, ack_d;
    logic [IW-1:0]     idx_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h7E;
            4'd1:    return 7'h30;
            4'd2:    return 7'h6D;
            4'd3:    return 7'h79;
            4'd4:    return 7'h33;
            4'd5:    return 7'h5B;
            4'd6:    return 7'h5F;
            4'd7:    return 7'h70;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h7B;
            default: return 7'h36;
        endcase
    endfunction

    function automatic logic is_leading_zero(input logic [W-1:0] d, input logic [IW-1:0] i);
        logic z;
        z = (i != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(i) && d[4*k +: 4] != 4'd0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        parked_d = parked_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ack_d    = 1'b0;
        fd_d     = 1'b0;
        seg_d    = '0;
        dig_en_d = '0;

        if (!bus.en) begin
            // Parked: nothing is visible, so commits need not wait for a frame edge.
            state_d  = ST_SHOW;
            idx_d    = '0;
            cnt_d    = '0;
            parked_d = 1'b1;
            if (bus.load) begin
                disp_d   = bus.value;
                pend_v_d = 1'b0;
                ack_d    = 1'b1;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
                ack_d    = 1'b1;
            end
        end else begin
            if (fd_q) begin
                if (bus.load) begin
                    disp_d = bus.value;
                end else if (pend_v_q) begin
                    disp_d = pend_q;
                end
                pend_v_d = 1'b0;
            end else if (bus.load) begin
                pend_d   = bus.value;
                pend_v_d = 1'b1;
            end

            // Leaving park holds SHOW(0) at cnt 0 so digit 0 gets its full dwell.
            if (parked_q) begin
                parked_d = 1'b0;
            end else begin
                case (state_q)
                    ST_SHOW: begin
                        if (cnt_q == SHOW_LAST) begin
                            cnt_d = '0;
                            if (GAP_CYCLES == 0) begin
                                idx_d = idx_next;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_SHOW;
                            idx_d   = idx_next;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: state_d = ST_SHOW;
                endcase
            end

            if (state_d == ST_SHOW) begin
                if (!(bus.lz_suppress && is_leading_zero(disp_d, idx_d))) begin
                    seg_d    = seg_decode(disp_d[4*idx_d +: 4]);
                    dig_en_d = NUM_DIGITS'(1) << idx_d;
                end
                fd_d = (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SHOW;
            idx_q    <= '0;
            cnt_q    <= '0;
            parked_q <= 1'b1;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            seg_q    <= '0;
            dig_en_q <= '0;
            fd_q     <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            parked_q <= parked_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
            fd_q     <= fd_d;
            ack_q    <= ack_d;
        end
    end

    // A frame-edge commit is acknowledged in the commit cycle itself, alongside frame_done.
    assign bus.load_ack   = !rst && (ack_q || (bus.en && fd_q && (pend_v_q || bus.load)));
    assign bus.seg        = seg_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_scan_display_ctrl.sv
// Randomized and directed bench for scan_display_ctrl against a frame-position reference model.
module tb_scan_display_ctrl;
    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 1;
    localparam int D = R + G;
    localparam int P = N * D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_display_ctrl_if #(.NUM_DIGITS(N)) bus ();

    scan_display_ctrl #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .GAP_CYCLES (G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h36, 7'h36, 7'h36, 7'h36, 7'h36, 7'h36};

    // Model: frame position t of the scan, committed/pending words, expected outputs this cycle.
    logic        run;
    int          t;
    logic [15:0] m_disp, m_pend;
    logic        m_pv, m_ackreg;
    logic [6:0]  e_seg;
    logic [N-1:0] e_dig;
    logic        e_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic l,
                                input logic [15:0] v, input logic lz);
        int digit;
        int w;
        logic [15:0] upper;
        if (r) begin
            run = 1'b0; t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0; m_ackreg = 1'b0;
        end else if (!e) begin
            run = 1'b0; t = 0;
            m_ackreg = l | m_pv;
            if (l) m_disp = v;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else begin
            m_ackreg = 1'b0;
            if (e_fd) begin
                if (l) m_disp = v;
                else if (m_pv) m_disp = m_pend;
                m_pv = 1'b0;
            end else if (l) begin
                m_pend = v;
                m_pv = 1'b1;
            end
            if (run) t = (t + 1) % P;
            else begin
                run = 1'b1;
                t = 0;
            end
        end
        e_seg = '0; e_dig = '0; e_fd = 1'b0;
        if (run) begin
            digit = t / D;
            w = t % D;
            if (w < R) begin
                upper = m_disp >> (4 * digit);
                if (!(lz && digit > 0 && upper == 16'h0)) begin
                    e_dig = N'(1 << digit);
                    e_seg = seg_tab[upper[3:0]];
                end
                e_fd = (digit == N - 1) && (w == R - 1);
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] v, input logic lz);
        logic exp_ack;
        @(negedge clk);
        rst = r; bus.en = e; bus.load = l; bus.value = v; bus.lz_suppress = lz;
        #1;
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("dig_en", 32'(bus.dig_en), 32'(e_dig));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        exp_ack = !r && (m_ackreg || (e && e_fd && (m_pv || l)));
        chk("load_ack", 32'(bus.load_ack), 32'(exp_ack));
        model_update(r, e, l, v, lz);
    endtask

    task automatic idle(input int n, input logic lz);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0, lz);
    endtask

    task automatic goto_pos(input int pos, input logic lz);
        int n = 0;
        while (!(run && t == pos) && n < 3 * P) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, lz);
            n++;
        end
        chk("goto_pos", 32'(run && t == pos), 32'd1);
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.lz_suppress = 1'b0;
        run = 1'b0; t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0; m_ackreg = 1'b0;
        e_seg = '0; e_dig = '0; e_fd = 1'b0;

        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(2 * P, 1'b0);

        goto_pos(D + 1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h1249, 1'b0);
        idle(2 * P, 1'b0);

        goto_pos(2, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h0001, 1'b1);
        goto_pos(8, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h0002, 1'b1);
        idle(2 * P, 1'b1);

        goto_pos(1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h0C05, 1'b0);
        idle(2 * P, 1'b0);
        goto_pos(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
        idle(2 * P, 1'b1);

        goto_pos(P - G - 1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h4321, 1'b0);
        idle(P + 2, 1'b0);

        goto_pos(2 * D + 1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h5678, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        idle(P + 2, 1'b0);

        goto_pos(R - 1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h9999, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        idle(P + 2, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic r_r, r_e, r_l, r_lz;
            logic [15:0] r_v;
            r_r  = ($urandom_range(0, 299) == 0);
            r_e  = ($urandom_range(0, 19) != 0);
            r_l  = ($urandom_range(0, 14) == 0);
            r_lz = ((i / 400) % 2) == 1;
            r_v  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 999));
            step(r_r, r_e, r_l, r_v, r_lz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
